uart_word_packer: RTL and testbench
===================================

// Module: uart_word_packer
// PURPOSE
//  Consumes the byte stream from the UART receiver (data/valid_out/data_end) and packs bytes into
//  WORD_BYTES-wide little-endian words for the bitonic sorter input. Groups words into frames: a frame
//  closes on data_end and its final word carries m_last. Buffers words in a FIFO behind a valid/ready port.
// PARAMETERS
//  WORD_BYTES  4   bytes per output word (>=2); first received byte lands in bits [7:0]
//  FIFO_DEPTH  16  word FIFO depth, power of two
// PORTS
//  clk        in   1              system clock
//  rst        in   1              asynchronous, active-high reset
//  s_data     in   8              received byte
//  s_valid    in   1              1-cycle strobe, s_data valid
//  s_end      in   1              1-cycle strobe, line idle long enough: close current frame
//  m_data     out  8*WORD_BYTES   packed word (FIFO head)
//  m_valid    out  1              m_data/m_last valid
//  m_ready    in   1              sink accepts; transfer when m_valid & m_ready
//  m_last     out  1              m_data is final word of its frame
//  frame_cnt  out  16             frames closed (non-empty only), wraps at 2^16
//  overflow   out  1              sticky: word lost to full FIFO
//  drop_err   out  1              sticky: byte arrived during CLOSE1/CLOSE2 and was discarded
// BEHAVIOUR
//  Reset: m_valid=0, m_last=0, m_data=0, frame_cnt=0, overflow=0, drop_err=0; state=ACCUM,
//   byte_cnt=0, acc=0, staged_valid=0, end_pend=0, FIFO empty. Reset mid-frame discards everything.
//  Internals: acc (accumulator), byte_cnt [$clog2(WORD_BYTES)], staged word register + staged_valid,
//   end_pend flag. Staging holds newest complete word until its last flag is known.
//  Push = write {last, word} into FIFO; if FIFO full the word is discarded and overflow<=1.
//  FSM states ACCUM, CLOSE1, CLOSE2:
//  ACCUM: s_valid -> acc[byte_cnt*8+:8]<=s_data, byte_cnt++. On byte_cnt==WORD_BYTES-1 word completes:
//   byte_cnt<=0; if staged_valid push staged (last=0); staged<={s_data,acc[lower]}; staged_valid<=1.
//   s_end (any cycle in ACCUM, incl. same cycle as s_valid) -> end_pend<=1; byte still processed.
//   end_pend=1 -> clear end_pend, go CLOSE1 (close starts one cycle after s_end).
//  CLOSE1: if byte_cnt!=0: push staged if staged_valid (last=0); staged<=acc zero-padded above
//   byte_cnt bytes; staged_valid<=1; byte_cnt<=0; acc<=0. Always -> CLOSE2.
//  CLOSE2: if staged_valid: push staged with last=1, staged_valid<=0, frame_cnt++. -> ACCUM.
//   Empty frame (no bytes since previous close): no push, frame_cnt unchanged.
//  s_valid in CLOSE1/CLOSE2: byte dropped, drop_err<=1. s_end in CLOSE1/CLOSE2: ignored.
//  Output: first-word-fall-through; m_valid=!fifo_empty; m_data/m_last show head combinationally
//   from FIFO registers; pop on m_valid&m_ready. Push and pop same cycle on full FIFO: pop frees
//   the slot, push succeeds (no overflow). Latency: word completion -> FIFO visible when next word
//   completes or 2 cycles after close start; staged word never visible before its last flag is fixed.
//  Pointers $clog2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, lower bits equal.
// STRUCTURE
//  Package uart_pkg: typedef enum logic [1:0] {ACCUM, CLOSE1, CLOSE2} pack_state_t; shared
//   BYTE_W=8 constant. Sub-module rx_word_fifo (sync FWFT FIFO, params WIDTH/DEPTH, full/empty,
//   same clk/rst) instantiated with WIDTH=8*WORD_BYTES+1. Packer FSM and staging in this module.
// TESTING (WORD_BYTES=4, FIFO_DEPTH=16, m_ready=1 unless stated)
//  Bytes 11,22,33,44,55,66,77,88 then s_end -> 44332211/last=0, 88776655/last=1; frame_cnt=1.
//  Bytes AA,BB,CC then s_end -> single word 00CCBBAA/last=1; frame_cnt=1.
//  s_end with no bytes (after reset and right after a closed frame) -> no m_valid, frame_cnt unchanged.
//  m_ready=0, 18 full words then s_end -> 16 words held, overflow=1; drain: first 16 words in order.
//  s_valid(44) and s_end same cycle after 11,22,33 -> 44332211/last=1; byte in CLOSE1 -> drop_err=1.
//  rst pulse after 2 bytes of a word -> all outputs reset; next frame 01,02,03,04+s_end -> 04030201/last=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side word packer.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ACCUM,
    CLOSE1,
    CLOSE2
  } pack_state_t;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is read combinationally from storage.
module rx_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes into little-endian words, marks the final word of each frame, buffers in a FIFO.
module uart_word_packer
  import uart_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BYTE_W-1:0]            s_data,
  input  logic                         s_valid,
  input  logic                         s_end,
  output logic [BYTE_W*WORD_BYTES-1:0] m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [15:0]                  frame_cnt,
  output logic                         overflow,
  output logic                         drop_err
);

  localparam int WW   = BYTE_W * WORD_BYTES;
  localparam int BC_W = $clog2(WORD_BYTES);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WORD_BYTES - 1);

  pack_state_t     state, state_n;
  logic [BC_W-1:0] byte_cnt, byte_cnt_n;
  logic [WW-1:0]   acc, acc_n;
  logic [WW-1:0]   staged, staged_n;
  logic            staged_valid, staged_valid_n;
  logic            end_pend, end_pend_n;
  logic [15:0]     frame_cnt_n;
  logic            drop_err_n;
  logic [WW-1:0]   pad_word;

  logic            push;
  logic            push_last;
  logic            pop;
  logic [WW:0]     head;
  logic            fifo_full;
  logic            fifo_empty;

  // Partial word at close: keep only the bytes received so far, older bytes above are stale.
  always_comb begin
    pad_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i < int'(byte_cnt)) pad_word[i*BYTE_W +: BYTE_W] = acc[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_n        = state;
    byte_cnt_n     = byte_cnt;
    acc_n          = acc;
    staged_n       = staged;
    staged_valid_n = staged_valid;
    end_pend_n     = end_pend;
    frame_cnt_n    = frame_cnt;
    drop_err_n     = drop_err;
    push           = 1'b0;
    push_last      = 1'b0;
    case (state)
      ACCUM: begin
        if (s_valid) begin
          acc_n[int'(byte_cnt)*BYTE_W +: BYTE_W] = s_data;
          if (byte_cnt == LAST_IDX) begin
            byte_cnt_n     = '0;
            push           = staged_valid;
            staged_n       = {s_data, acc[BYTE_W*(WORD_BYTES-1)-1:0]};
            staged_valid_n = 1'b1;
          end else begin
            byte_cnt_n = byte_cnt + BC_W'(1);
          end
        end
        if (end_pend) begin
          end_pend_n = 1'b0;
          state_n    = CLOSE1;
        end else if (s_end) begin
          end_pend_n = 1'b1;
        end
      end
      CLOSE1: begin
        if (byte_cnt != '0) begin
          push           = staged_valid;
          staged_n       = pad_word;
          staged_valid_n = 1'b1;
          byte_cnt_n     = '0;
          acc_n          = '0;
        end
        if (s_valid) drop_err_n = 1'b1;
        state_n = CLOSE2;
      end
      CLOSE2: begin
        if (staged_valid) begin
          push           = 1'b1;
          push_last      = 1'b1;
          staged_valid_n = 1'b0;
          frame_cnt_n    = frame_cnt + 16'd1;
        end
        if (s_valid) drop_err_n = 1'b1;
        state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      byte_cnt     <= '0;
      acc          <= '0;
      staged       <= '0;
      staged_valid <= 1'b0;
      end_pend     <= 1'b0;
      frame_cnt    <= '0;
      drop_err     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      byte_cnt     <= byte_cnt_n;
      acc          <= acc_n;
      staged       <= staged_n;
      staged_valid <= staged_valid_n;
      end_pend     <= end_pend_n;
      frame_cnt    <= frame_cnt_n;
      drop_err     <= drop_err_n;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign pop = m_ready && !fifo_empty;

  rx_word_fifo #(
    .WIDTH (WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({push_last, staged}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : head[WW-1:0];
  assign m_last  = fifo_empty ? 1'b0 : head[WW];

endmodule

// File: tb/tb_uart_word_packer.sv
// Randomized and directed bench for uart_word_packer against a frame-level packing model.
module tb_uart_word_packer;

  localparam int WB = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_end;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] frame_cnt;
  logic        overflow;
  logic        drop_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_frames = 0;
  bit          rand_ready = 1'b0;
  logic [32:0] got_q [$];
  logic [32:0] exp_q [$];
  logic [7:0]  cur_bytes [$];

  uart_word_packer #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_end     (s_end),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_cnt (frame_cnt),
    .overflow  (overflow),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a negedge handshake means a transfer at the next edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_data});
  end

  task checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task applyStimulus(input logic v, input logic [7:0] d, input logic e);
    s_valid = v;
    s_data  = d;
    s_end   = e;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_end   = 1'b0;
  endtask

  task idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  // Frame-level model: split the frame's bytes into little-endian words, zero-pad the tail.
  task modelClose();
    int n;
    int nw;
    logic [31:0] word;
    n  = cur_bytes.size();
    nw = (n + WB - 1) / WB;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int b = 0; b < WB; b++) begin
        if (w * WB + b < n) word[b*8 +: 8] = cur_bytes[w * WB + b];
      end
      exp_q.push_back({(w == nw - 1), word});
    end
    if (n > 0) exp_frames++;
    cur_bytes.delete();
  endtask

  task sendByte(input logic [7:0] b, input logic e);
    cur_bytes.push_back(b);
    applyStimulus(1'b1, b, e);
    if (e) modelClose();
  endtask

  task sendEnd();
    applyStimulus(1'b0, 8'h00, 1'b1);
    modelClose();
  endtask

  task clearModel();
    cur_bytes.delete();
    exp_q.delete();
    got_q.delete();
    exp_frames = 0;
  endtask

  task doReset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_end   = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
  endtask

  task checkResetOutputs(input string tag);
    checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_m_last"}, 64'(m_last), 64'd0);
    checkOutput({tag, "_m_data"}, 64'(m_data), 64'd0);
    checkOutput({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
    checkOutput({tag, "_drop_err"}, 64'(drop_err), 64'd0);
  endtask

  task checkHead(input string tag, input int idx, input logic [32:0] exp);
    if (idx < got_q.size()) checkOutput(tag, 64'(got_q[idx]), 64'(exp));
    else checkOutput({tag, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
  endtask

  task compareQueues(input string tag);
    int n;
    checkOutput({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] seq8 [8];
    int         n;
    int         gap;
    seq8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    doReset();
    checkResetOutputs("reset");

    // Two full words in one frame
    for (int i = 0; i < 8; i++) sendByte(seq8[i], 1'b0);
    sendEnd();
    idle(6);
    checkHead("two_words_w0", 0, 33'h0_44332211);
    checkHead("two_words_w1", 1, 33'h1_88776655);
    checkOutput("two_words_frame_cnt", 64'(frame_cnt), 64'd1);
    compareQueues("two_words");

    // Partial word padded with zeros
    doReset();
    sendByte(8'hAA, 1'b0);
    sendByte(8'hBB, 1'b0);
    sendByte(8'hCC, 1'b0);
    sendEnd();
    idle(6);
    checkHead("partial_w0", 0, 33'h1_00CCBBAA);
    checkOutput("partial_frame_cnt", 64'(frame_cnt), 64'd1);
    compareQueues("partial");

    // Empty frames after reset and after a closed frame
    doReset();
    sendEnd();
    idle(6);
    checkOutput("empty_reset_words", 64'(got_q.size()), 64'd0);
    checkOutput("empty_reset_frame_cnt", 64'(frame_cnt), 64'd0);
    sendByte(8'h5A, 1'b0);
    sendByte(8'hA5, 1'b0);
    sendEnd();
    idle(6);
    compareQueues("pre_empty");
    sendEnd();
    idle(6);
    checkOutput("empty_after_words", 64'(got_q.size()), 64'd0);
    checkOutput("empty_after_frame_cnt", 64'(frame_cnt), 64'd1);

    // Overflow: 18 words with the sink stalled
    doReset();
    m_ready = 1'b0;
    for (int i = 0; i < 18 * WB; i++) sendByte(8'($urandom_range(0, 255)), 1'b0);
    sendEnd();
    idle(4);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_m_valid", 64'(m_valid), 64'd1);
    checkOutput("ovf_frame_cnt", 64'(frame_cnt), 64'd1);
    m_ready = 1'b1;
    idle(24);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    compareQueues("ovf_drain");

    // Byte with s_end on the same cycle, then a byte dropped during close
    doReset();
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0);
    sendByte(8'h44, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0);
    idle(6);
    checkHead("same_cycle_w0", 0, 33'h1_44332211);
    checkOutput("drop_err", 64'(drop_err), 64'd1);
    checkOutput("drop_overflow", 64'(overflow), 64'd0);
    compareQueues("same_cycle");

    // Reset pulse in the middle of a word
    doReset();
    sendByte(8'hDE, 1'b0);
    sendByte(8'hAD, 1'b0);
    #2;
    rst = 1'b1;
    #2;
    checkResetOutputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h04, 1'b1);
    idle(6);
    checkHead("after_reset_w0", 0, 33'h1_04030201);
    checkOutput("after_reset_frame_cnt", 64'(frame_cnt), 64'd1);
    compareQueues("after_reset");

    // Random frames with a randomly stalling sink
    doReset();
    rand_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      n = $urandom_range(0, 13);
      for (int i = 0; i < n; i++) begin
        gap = $urandom_range(0, 2);
        idle(gap);
        if (i == n - 1 && $urandom_range(0, 1) == 1) sendByte(8'($urandom_range(0, 255)), 1'b1);
        else sendByte(8'($urandom_range(0, 255)), 1'b0);
      end
      if (cur_bytes.size() > 0 || n == 0) sendEnd();
      idle(3);
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    idle(40);
    compareQueues("rand");
    checkOutput("rand_frame_cnt", 64'(frame_cnt), 64'(16'(exp_frames)));
    checkOutput("rand_overflow", 64'(overflow), 64'd0);
    checkOutput("rand_drop_err", 64'(drop_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
